// File: rtl/wb_stage.sv
// Writeback stage: single-entry output register feeding the register file write port and forwarding network.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module wb_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_we,
  input  logic            in_is_load,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_load_data,
  input  logic            hold,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic            retire_valid,
  output logic [XLEN-1:0] retire_pc,
  output logic            exc_misalign,
  output logic [63:0]     instret
);

  localparam int unsigned RW = 5;
  localparam int unsigned CW = 64;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [RW-1:0]   r_rd;
  logic            r_rd_we;
  logic            r_exc;
  logic [XLEN-1:0] r_data;

  logic            drain;
  logic            xfer;
  logic            writes_rd;
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic [XLEN-1:0] fmt_data;
  logic            fmt_exc;

  // Load data extraction and alignment / funct3 legality check
  always_comb begin
    sel_byte = in_load_data[7:0];
    case (in_addr_lo)
      2'd1:    sel_byte = in_load_data[15:8];
      2'd2:    sel_byte = in_load_data[23:16];
      2'd3:    sel_byte = in_load_data[31:24];
      default: sel_byte = in_load_data[7:0];
    endcase
    sel_half = in_addr_lo[1] ? in_load_data[31:16] : in_load_data[15:0];
    fmt_data = in_alu_result;
    fmt_exc  = 1'b0;
    if (in_is_load) begin
      fmt_data = '0;
      case (in_funct3)
        3'd0: fmt_data = {{24{sel_byte[7]}}, sel_byte};
        3'd4: fmt_data = {24'h0, sel_byte};
        3'd1: begin
          if (in_addr_lo[0]) fmt_exc = 1'b1;
          else               fmt_data = {{16{sel_half[15]}}, sel_half};
        end
        3'd5: begin
          if (in_addr_lo[0]) fmt_exc = 1'b1;
          else               fmt_data = {16'h0, sel_half};
        end
        3'd2: begin
          if (in_addr_lo != 2'd0) fmt_exc = 1'b1;
          else                    fmt_data = in_load_data;
        end
        default: fmt_exc = 1'b1;
      endcase
    end
  end

  assign in_ready = !r_valid || !hold;
  assign xfer     = in_valid && in_ready;
  assign drain    = r_valid && !hold;

  // Entry register: a drain and a transfer in the same cycle replace without a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_rd    <= '0;
      r_rd_we <= 1'b0;
      r_exc   <= 1'b0;
      r_data  <= '0;
    end else if (xfer) begin
      r_valid <= 1'b1;
      r_pc    <= in_pc;
      r_rd    <= in_rd;
      r_rd_we <= in_rd_we;
      r_exc   <= fmt_exc;
      r_data  <= fmt_data;
    end else if (drain) begin
      r_valid <= 1'b0;
    end
  end

  assign writes_rd    = r_rd_we && (r_rd != RW'(0)) && !r_exc;
  assign rf_we        = drain && writes_rd;
  assign rf_waddr     = r_rd;
  assign rf_wdata     = r_data;
  assign fwd_valid    = r_valid && writes_rd;
  assign fwd_rd       = r_rd;
  assign fwd_data     = r_data;
  assign retire_valid = drain && !r_exc;
  assign retire_pc    = r_pc;
  assign exc_misalign = r_valid && r_exc;

`ifdef WB_INSTRET_EN
  logic [CW-1:0] r_instret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_instret <= '0;
    else if (retire_valid) r_instret <= r_instret + CW'(1);
  end

  assign instret = r_instret;
`else
  assign instret = CW'(0);
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a randomized run against a behavioural model.
module tb_wb_stage;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rd;
  logic        in_rd_we, in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_result, in_load_data;
  logic        hold;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic        exc_misalign;
  logic [63:0] instret;

  int n_cmp = 0;
  int n_fail = 0;

  wb_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result), .in_load_data(in_load_data),
    .hold(hold), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .exc_misalign(exc_misalign),
    .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are sampled 4ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                         input logic ld, input logic [2:0] f3, input logic [1:0] lo,
                         input logic [31:0] alu, input logic [31:0] raw);
    in_valid = 1'b1; in_pc = pc; in_rd = rd; in_rd_we = we; in_is_load = ld;
    in_funct3 = f3; in_addr_lo = lo; in_alu_result = alu; in_load_data = raw;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_pc = '0; in_rd = '0; in_rd_we = 1'b0; in_is_load = 1'b0;
    in_funct3 = '0; in_addr_lo = '0; in_alu_result = '0; in_load_data = '0;
  endtask

  // Reference load formatter built from shifts and arithmetic sign handling
  function automatic void ref_fmt(input logic ld, input logic [2:0] f3, input logic [1:0] lo,
                                  input logic [31:0] alu, input logic [31:0] raw,
                                  output logic [31:0] d, output logic e);
    int unsigned v;
    d = alu; e = 1'b0;
    if (ld) begin
      d = '0;
      if (f3 == 3'd0 || f3 == 3'd4) begin
        v = (raw >> (8 * 32'(lo))) & 32'hFF;
        if (f3 == 3'd0 && v >= 128) v = v - 256;
        d = v;
      end else if (f3 == 3'd1 || f3 == 3'd5) begin
        if (lo % 2 == 1) e = 1'b1;
        else begin
          v = (raw >> (8 * 32'(lo))) & 32'hFFFF;
          if (f3 == 3'd1 && v >= 32768) v = v - 65536;
          d = v;
        end
      end else if (f3 == 3'd2) begin
        if (lo != 0) e = 1'b1;
        else d = raw;
      end else e = 1'b1;
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1; hold = 1'b0; idle_inputs();
    #3;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if ({rf_we, fwd_valid, retire_valid, exc_misalign} !== 4'b0) begin n_fail++;
      $display("FAIL reset_flags got=%b exp=0000", {rf_we, fwd_valid, retire_valid, exc_misalign}); end
    n_cmp++; if ({rf_waddr, rf_wdata, fwd_rd, fwd_data, retire_pc, instret} !== '0) begin n_fail++;
      $display("FAIL reset_data got nonzero wdata=%h pc=%h instret=%0d", rf_wdata, retire_pc, instret); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_alu_write();
    tick(); present(32'h0000_1000, 5'd5, 1'b1, 1'b0, 3'd0, 2'd0, 32'h1234_5678, 32'h0);
    tick(); idle_inputs(); #4;
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h1234_5678}) begin n_fail++;
      $display("FAIL alu_write got we=%b a=%0d d=%h exp we=1 a=5 d=12345678", rf_we, rf_waddr, rf_wdata); end
    n_cmp++; if ({retire_valid, retire_pc} !== {1'b1, 32'h0000_1000}) begin n_fail++;
      $display("FAIL alu_retire got v=%b pc=%h exp v=1 pc=00001000", retire_valid, retire_pc); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3 [5] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5};
    logic [1:0]  lo [5] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0};
    logic [31:0] ex [5] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
    for (int i = 0; i < 5; i++) begin
      tick(); present(32'h200 + 32'(4 * i), 5'd7, 1'b1, 1'b1, f3[i], lo[i], 32'hDEAD_BEEF, 32'h80FF_7F01);
      tick(); idle_inputs(); #4;
      n_cmp++; if ({rf_we, rf_wdata, exc_misalign} !== {1'b1, ex[i], 1'b0}) begin n_fail++;
        $display("FAIL load_%0d got we=%b d=%h exc=%b exp we=1 d=%h exc=0", i, rf_we, rf_wdata, exc_misalign, ex[i]); end
    end
  endtask

  task automatic test_x0_misalign();
    tick(); present(32'h300, 5'd0, 1'b1, 1'b0, 3'd0, 2'd0, 32'hAAAA_5555, 32'h0);
    tick(); idle_inputs(); #4;
    n_cmp++; if ({rf_we, fwd_valid, retire_valid} !== 3'b001) begin n_fail++;
      $display("FAIL x0_write got we/fwd/ret=%b exp 001", {rf_we, fwd_valid, retire_valid}); end
    tick(); present(32'h304, 5'd9, 1'b1, 1'b1, 3'd2, 2'd2, 32'h0, 32'h1111_2222);
    tick(); idle_inputs(); #4;
    n_cmp++; if ({exc_misalign, rf_we, retire_valid, fwd_valid} !== 4'b1000) begin n_fail++;
      $display("FAIL lw_misalign got exc/we/ret/fwd=%b exp 1000", {exc_misalign, rf_we, retire_valid, fwd_valid}); end
    n_cmp++; if (rf_wdata !== 32'h0) begin n_fail++; $display("FAIL lw_misalign_data got=%h exp=0", rf_wdata); end
  endtask

  task automatic test_hold();
    tick(); hold = 1'b1; present(32'h400, 5'd3, 1'b1, 1'b0, 3'd0, 2'd0, 32'hCAFE_0003, 32'h0);
    #4;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_empty_ready got=%b exp=1", in_ready); end
    tick(); idle_inputs();
    for (int c = 0; c < 3; c++) begin
      #4;
      n_cmp++; if ({in_ready, fwd_valid, fwd_rd, fwd_data, rf_we} !== {1'b0, 1'b1, 5'd3, 32'hCAFE_0003, 1'b0}) begin
        n_fail++; $display("FAIL hold_cycle_%0d got rdy=%b fwd=%b rd=%0d d=%h we=%b exp rdy=0 fwd=1 rd=3 d=cafe0003 we=0",
                           c, in_ready, fwd_valid, fwd_rd, fwd_data, rf_we); end
      tick();
    end
    hold = 1'b0; present(32'h404, 5'd4, 1'b1, 1'b0, 3'd0, 2'd0, 32'hCAFE_0004, 32'h0);
    #4;
    n_cmp++; if ({in_ready, rf_we, rf_waddr, retire_pc} !== {1'b1, 1'b1, 5'd3, 32'h400}) begin n_fail++;
      $display("FAIL hold_release got rdy=%b we=%b a=%0d pc=%h exp rdy=1 we=1 a=3 pc=400", in_ready, rf_we, rf_waddr, retire_pc); end
    tick(); idle_inputs(); #4;
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'hCAFE_0004}) begin n_fail++;
      $display("FAIL hold_next got we=%b a=%0d d=%h exp we=1 a=4 d=cafe0004", rf_we, rf_waddr, rf_wdata); end
    tick(); #4;
    n_cmp++; if ({rf_we, fwd_valid} !== 2'b00) begin n_fail++; $display("FAIL hold_drained got we/fwd=%b exp 00", {rf_we, fwd_valid}); end
  endtask

  task automatic test_back_to_back();
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) present(32'h500 + 32'(4 * i), 5'(10 + i), 1'b1, 1'b0, 3'd0, 2'd0, 32'h1000 + 32'(i), 32'h0);
      else idle_inputs();
      #4;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d got=%b exp=1", i, in_ready); end
      if (i > 0) begin
        n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'(9 + i), 32'h1000 + 32'(i - 1)}) begin n_fail++;
          $display("FAIL b2b_write_%0d got we=%b a=%0d d=%h exp we=1 a=%0d d=%h", i, rf_we, rf_waddr, rf_wdata,
                   9 + i, 32'h1000 + 32'(i - 1)); end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] exp_ir;
    hold = 1'b1; present(32'h600, 5'd6, 1'b1, 1'b0, 3'd0, 2'd0, 32'h6666, 32'h0);
    tick(); idle_inputs(); #2;
    rst = 1'b1; #1;
    n_cmp++; if ({in_ready, rf_we, fwd_valid, retire_valid, exc_misalign} !== 5'b10000) begin n_fail++;
      $display("FAIL async_rst_flags got=%b exp 10000", {in_ready, rf_we, fwd_valid, retire_valid, exc_misalign}); end
    n_cmp++; if ({rf_waddr, fwd_data, retire_pc, instret} !== '0) begin n_fail++;
      $display("FAIL async_rst_data got a=%0d d=%h pc=%h ir=%0d exp all 0", rf_waddr, fwd_data, retire_pc, instret); end
    @(negedge clk); rst = 1'b0; hold = 1'b0;
    tick(); #4;
    n_cmp++; if ({rf_we, retire_valid} !== 2'b00) begin n_fail++; $display("FAIL async_rst_nowrite got=%b exp 00", {rf_we, retire_valid}); end
    for (int i = 0; i < 3; i++) begin
      tick(); present(32'h700 + 32'(4 * i), 5'd1, 1'b1, 1'b0, 3'd0, 2'd0, 32'(i), 32'h0);
    end
    tick(); idle_inputs(); tick(); #4;
`ifdef WB_INSTRET_EN
    exp_ir = 64'd3;
`else
    exp_ir = 64'd0;
`endif
    n_cmp++; if (instret !== exp_ir) begin n_fail++; $display("FAIL instret_after3 got=%0d exp=%0d", instret, exp_ir); end
  endtask

  task automatic test_random();
    logic        m_valid, m_we, m_exc, e_ready, e_drain, e_wr, t_valid;
    logic [4:0]  m_rd;
    logic [31:0] m_pc, m_data, nd, e_pc;
    logic        ne;
    logic [63:0] m_ret;
    rst = 1'b1; #2; rst = 1'b0;
    m_valid = 1'b0; m_we = 1'b0; m_exc = 1'b0; m_rd = '0; m_pc = '0; m_data = '0; m_ret = '0;
    for (int c = 0; c < 400; c++) begin
      tick();
      hold = ($urandom_range(0, 9) < 3);
      t_valid = ($urandom_range(0, 3) != 0);
      present($urandom, 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom);
      in_valid = t_valid;
      #4;
      e_ready = !m_valid || !hold;
      e_drain = m_valid && !hold;
      e_wr    = m_we && m_rd != 0 && !m_exc;
      n_cmp++; if (in_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, e_ready); end
      n_cmp++; if ({rf_we, retire_valid, fwd_valid, exc_misalign} !== {e_drain && e_wr, e_drain && !m_exc, m_valid && e_wr, m_valid && m_exc}) begin
        n_fail++; $display("FAIL rnd_flags c=%0d got=%b exp=%b", c, {rf_we, retire_valid, fwd_valid, exc_misalign},
                           {e_drain && e_wr, e_drain && !m_exc, m_valid && e_wr, m_valid && m_exc}); end
      if (m_valid) begin
        e_pc = m_pc;
        n_cmp++; if ({rf_waddr, rf_wdata, fwd_data, retire_pc} !== {m_rd, m_data, m_data, e_pc}) begin n_fail++;
          $display("FAIL rnd_data c=%0d got a=%0d d=%h f=%h pc=%h exp a=%0d d=%h pc=%h", c, rf_waddr, rf_wdata, fwd_data,
                   retire_pc, m_rd, m_data, e_pc); end
      end
`ifdef WB_INSTRET_EN
      n_cmp++; if (instret !== m_ret) begin n_fail++; $display("FAIL rnd_instret c=%0d got=%0d exp=%0d", c, instret, m_ret); end
`else
      n_cmp++; if (instret !== 64'd0) begin n_fail++; $display("FAIL rnd_instret c=%0d got=%0d exp=0", c, instret); end
`endif
      if (e_drain && !m_exc) m_ret = m_ret + 1;
      if (t_valid && e_ready) begin
        ref_fmt(in_is_load, in_funct3, in_addr_lo, in_alu_result, in_load_data, nd, ne);
        m_valid = 1'b1; m_pc = in_pc; m_rd = in_rd; m_we = in_rd_we; m_exc = ne; m_data = nd;
      end else if (e_drain) m_valid = 1'b0;
    end
    tick(); idle_inputs(); hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_loads();
    test_x0_misalign();
    test_hold();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the RISC-V core, directly upstream of the register file write port.
- Accepts one completed instruction per cycle from the memory stage and holds it in a single-entry output register.
- Formats load data (byte/half/word, signed/unsigned) and drives the register file's we/waddr/wdata.
- Exposes the held result as a forwarding source, because the register file has no write-to-read bypass.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  memory stage presents an instruction
- in_ready  output  1  stage can accept this cycle
- in_pc  input  32  PC of the instruction
- in_rd  input  5  destination register
- in_rd_we  input  1  instruction writes rd
- in_is_load  input  1  result comes from load data, not the ALU
- in_funct3  input  3  load size/sign: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu
- in_addr_lo  input  2  low two bits of the load address
- in_alu_result  input  32  ALU/CSR result
- in_load_data  input  32  raw aligned memory word
- hold  input  1  freezes retirement (debug halt / external stall)
- rf_we  output  1  register file write enable
- rf_waddr  output  5  register file write address
- rf_wdata  output  32  register file write data
- fwd_valid  output  1  held entry carries a valid rd value
- fwd_rd  output  5  forwarded register index
- fwd_data  output  32  forwarded value
- retire_valid  output  1  one pulse per retired instruction
- retire_pc  output  32  PC of the retiring instruction
- exc_misalign  output  1  held load is misaligned or uses an illegal funct3
- instret  output  64  retired-instruction count (optional feature)

Behaviour:
- State: r_valid plus a registered copy of pc, rd, rd_we, exc and the formatted data.
- Reset (async, rst=1):
  - r_valid=0, all held fields=0.
  - Every output is 0 except in_ready, which is 1.
- Handshake:
  - in_ready = !r_valid || !hold.
  - Transfer when in_valid && in_ready.
  - Data is captured on the following rising edge; with no hold, that is 1-cycle latency from input to rf_we.
- drain = r_valid && !hold.
  - On a drain with no new transfer, r_valid clears.
  - A drain and a transfer in the same cycle replace the entry with no bubble.
- Load formatting when in_is_load=1; byte/half is selected by in_addr_lo:
  - lb/lbu: byte [8*addr_lo+7 : 8*addr_lo], sign- or zero-extended.
  - lh/lhu: half at addr_lo[1]; misaligned if addr_lo[0]=1.
  - lw: misaligned if addr_lo!=0.
  - funct3 3/6/7 is illegal.
  - On misalign or illegal funct3: exc=1 and data=0.
- Non-load: data=in_alu_result; exc=0.
- rf_we = drain && r_rd_we && (r_rd!=0) && !r_exc.
  - rf_waddr = r_rd and rf_wdata = r_data whenever r_valid, regardless of rf_we.
  - rf_we is never asserted twice for one entry.
- fwd_valid = r_valid && r_rd_we && r_rd!=0 && !r_exc.
  - Stays asserted throughout a hold, because the register file is not yet written.
  - fwd_rd = r_rd and fwd_data = r_data.
- retire_valid = drain && !r_exc.
  - retire_pc = r_pc.
  - Excepting instructions do not retire.
- exc_misalign = r_valid && r_exc.
  - The entry still drains; trap redirect is handled upstream.
- hold asserted with r_valid=0: in_ready=1, and one instruction may enter and then wait.
- Reset mid-hold discards the entry; no write occurs.

Optional Feature:
- Macro: WB_INSTRET_EN.
- Defined: 64-bit counter instret, reset 0, increments by 1 on each retire_valid cycle and wraps from 2^64-1 to 0.
- Undefined: no counter is synthesised and instret is tied to 0.

Test Plan:
- ALU write: in_rd=5, in_rd_we=1, in_alu_result=0x1234_5678, hold=0 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678, retire_valid=1, retire_pc=in_pc.
- Loads from in_load_data=0x80FF_7F01:
  - lb, addr_lo=1 -> 0x0000007F.
  - lb, addr_lo=2 -> 0xFFFFFFFF.
  - lbu, addr_lo=3 -> 0x00000080.
  - lh, addr_lo=2 -> 0xFFFF80FF.
  - lhu, addr_lo=0 -> 0x00007F01.
- x0 and misalign:
  - in_rd=0 -> rf_we=0, fwd_valid=0, retire_valid=1.
  - lw with addr_lo=2 -> exc_misalign=1, rf_we=0, retire_valid=0.
- Hold: entry rd=3 held for 3 cycles -> in_ready=0, fwd_valid=1 with fwd_data stable, rf_we=0; on hold release exactly one rf_we pulse; back-to-back input accepted in the same cycle.
- Back-to-back stream: 4 instructions on consecutive cycles with hold=0 -> 4 consecutive rf_we pulses, in_ready constantly 1, in order.
- Reset: assert rst asynchronously while an entry is held -> all outputs 0 immediately, in_ready=1; with WB_INSTRET_EN, instret=0, and after 3 retirements instret=3.
